// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave and the report controller.
//   state_t      : slave FSM state codes, as reported on i2c_state
//   DEFAULT_ADDR : default 7-bit slave address
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_SHIFT = 3'd1,
    ACK_ADDR   = 3'd2,
    TX_BYTE    = 3'd3,
    MACK       = 3'd4,
    NEXT_BYTE  = 3'd5
  } state_t;

  localparam logic [6:0] DEFAULT_ADDR = 7'h64;

endpackage

// File: rtl/i2c_report_ctrl_if.sv
// -----------------------------------------------------------------------------
// i2c_report_ctrl_if
// Bundles the requester side (req/gnt/data) and the I2C slave side
// (i2c_state in, snapshot bytes/irq/frame_cnt/stale out) of the report
// controller.
//   modport slave  : the report controller
//   modport master : requesters + I2C slave (or a testbench standing in for them)
// -----------------------------------------------------------------------------
interface i2c_report_ctrl_if;

  i2c_pkg::state_t i2c_state;
  logic [2:0]      req;
  logic [2:0]      gnt;
  logic [7:0]      cur_x;
  logic [7:0]      cur_y;
  logic [7:0]      status_in;
  logic [7:0]      brush_in;
  logic [7:0]      x_pos;
  logic [7:0]      y_pos;
  logic [7:0]      status;
  logic [7:0]      brush_status;
  logic            irq;
  logic [7:0]      frame_cnt;
  logic            stale;

  modport slave (
    input  i2c_state, req, cur_x, cur_y, status_in, brush_in,
    output gnt, x_pos, y_pos, status, brush_status, irq, frame_cnt, stale
  );

  modport master (
    output i2c_state, req, cur_x, cur_y, status_in, brush_in,
    input  gnt, x_pos, y_pos, status, brush_status, irq, frame_cnt, stale
  );

endinterface

// File: rtl/rr_arbiter3.sv
// -----------------------------------------------------------------------------
// rr_arbiter3
// Three-way round-robin arbiter. Grant is combinational and one-hot; the
// search starts at the pointer and wraps modulo 3. After a grant to k the
// pointer moves to (k+1) mod 3.
//   clk, rst_n : clock, async active-low reset
//   i_req[2:0] : request vector
//   o_gnt[2:0] : one-hot grant, 0 when i_req == 0
// -----------------------------------------------------------------------------
module rr_arbiter3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_req,
  output logic [2:0] o_gnt
);

  logic [1:0] r_ptr;

  always_comb begin
    o_gnt = 3'b000;
    case (r_ptr)
      2'd1: begin
        if      (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      2'd2: begin
        if      (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      default: begin
        if      (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= 2'd0;
    else if (o_gnt[0]) r_ptr <= 2'd1;
    else if (o_gnt[1]) r_ptr <= 2'd2;
    else if (o_gnt[2]) r_ptr <= 2'd0;
  end

endmodule

// File: rtl/i2c_report_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_report_ctrl
// Owns the 4-byte I2C read report. Three requesters share one write port into
// a live bank via a round-robin arbiter; a snapshot bank copies the live bank
// one cycle later except while the slave is mid-transaction (frozen so the
// master reads a coherent report). A freeze held too long is abandoned and
// flagged as stale. irq tells the host new data is waiting; frame_cnt counts
// completed reads.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport of i2c_report_ctrl_if
//                in : i2c_state, req[2:0], cur_x, cur_y, status_in, brush_in
//                out: gnt[2:0], x_pos, y_pos, status, brush_status, irq,
//                     frame_cnt, stale
// -----------------------------------------------------------------------------
module i2c_report_ctrl
  import i2c_pkg::*;
#(
  parameter logic [15:0] FREEZE_TIMEOUT = 16'd50000,
  parameter logic [2:0]  REPORT_BYTES   = 3'd4
) (
  input logic              clk,
  input logic              rst_n,
  i2c_report_ctrl_if.slave bus
);

  logic [2:0]  w_gnt;
  logic        w_wr;
  logic        w_busy;
  logic        w_fall;
  logic        w_timed_out;
  logic        w_byte_edge;
  logic        w_complete;

  logic [7:0]  r_live_x, r_live_y, r_live_st, r_live_br;
  logic [7:0]  r_snap_x, r_snap_y, r_snap_st, r_snap_br;
  logic        r_busy_d;
  state_t      r_state_d;
  logic [2:0]  r_byte_cnt;
  logic [15:0] r_to_cnt;
  logic        r_dirty;
  logic        r_pending;
  logic [7:0]  r_frame_cnt;

  rr_arbiter3 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (bus.req),
    .o_gnt (w_gnt)
  );

  assign w_wr        = |w_gnt;
  assign w_busy      = (bus.i2c_state != IDLE);
  assign w_fall      = r_busy_d && !w_busy;
  assign w_timed_out = (r_to_cnt == FREEZE_TIMEOUT);
  assign w_byte_edge = (r_state_d == TX_BYTE) && (bus.i2c_state == MACK);
  // A timed-out transaction never counts, even if all bytes went out: the
  // master may have read a torn report.
  assign w_complete  = w_fall && (r_byte_cnt >= REPORT_BYTES) && !w_timed_out;

  // Live bank: written by whichever requester holds the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live_x  <= 8'h00;
      r_live_y  <= 8'h00;
      r_live_st <= 8'h00;
      r_live_br <= 8'h00;
    end else begin
      if (w_gnt[0]) begin
        r_live_x <= bus.cur_x;
        r_live_y <= bus.cur_y;
      end
      if (w_gnt[1]) r_live_st <= bus.status_in;
      if (w_gnt[2]) r_live_br <= bus.brush_in;
    end
  end

  // Snapshot bank: one cycle behind live, frozen while busy unless the
  // freeze has timed out. Because busy is sampled from the slave's current
  // state, a write landing on the edge busy rises is left out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_x  <= 8'h00;
      r_snap_y  <= 8'h00;
      r_snap_st <= 8'h00;
      r_snap_br <= 8'h00;
    end else if (!w_busy || w_timed_out) begin
      r_snap_x  <= r_live_x;
      r_snap_y  <= r_live_y;
      r_snap_st <= r_live_st;
      r_snap_br <= r_live_br;
    end
  end

  // Transaction tracking: busy edge, byte count, freeze timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_d   <= 1'b0;
      r_state_d  <= IDLE;
      r_byte_cnt <= 3'd0;
      r_to_cnt   <= 16'd0;
    end else begin
      r_busy_d  <= w_busy;
      r_state_d <= bus.i2c_state;
      if (w_fall)
        r_byte_cnt <= 3'd0;
      else if (w_byte_edge && r_byte_cnt != 3'd7)
        r_byte_cnt <= r_byte_cnt + 3'd1;
      if (!w_busy)
        r_to_cnt <= 16'd0;
      else if (!w_timed_out)
        r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Data-ready bookkeeping. pending remembers writes the master could not
  // see because the snapshot was frozen; they keep irq up after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty     <= 1'b0;
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else if (w_fall) begin
      r_pending <= 1'b0;
      if (w_complete) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_dirty     <= r_pending || w_wr;
      end else begin
        r_dirty     <= r_dirty || r_pending || w_wr;
      end
    end else if (w_wr) begin
      r_dirty <= 1'b1;
      if (w_busy) r_pending <= 1'b1;
    end
  end

  assign bus.gnt          = w_gnt;
  assign bus.x_pos        = r_snap_x;
  assign bus.y_pos        = r_snap_y;
  assign bus.status       = r_snap_st;
  assign bus.brush_status = r_snap_br;
  assign bus.irq          = r_dirty;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.stale        = w_timed_out;

endmodule

// File: tb/tb_i2c_report_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_report_ctrl
// Directed bench. dut_a uses the default freeze timeout; dut_t uses a short
// timeout of 8 cycles so the stale path can be exercised quickly.
// -----------------------------------------------------------------------------
module tb_i2c_report_ctrl;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  i2c_report_ctrl_if bus_a ();
  i2c_report_ctrl_if bus_t ();

  i2c_report_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  i2c_report_ctrl #(.FREEZE_TIMEOUT(16'd8), .REPORT_BYTES(3'd4))
    dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_state(input bit sel, input state_t s);
    if (sel) bus_t.i2c_state = s;
    else     bus_a.i2c_state = s;
  endtask

  // One slave transaction. nbytes bytes go out (TX_BYTE->MACK each), with
  // NEXT_BYTE between bytes; stopping after fewer than four models a master
  // NACK. nack_addr ends right after the address phase. wr_mid fires a brush
  // write into dut_a on the first MACK edge.
  task automatic run_read(input bit sel, input int nbytes, input bit wr_mid,
                          input bit nack_addr);
    set_state(sel, ADDR_SHIFT); tick();
    set_state(sel, ACK_ADDR);   tick();
    if (!nack_addr) begin
      for (int b = 0; b < nbytes; b++) begin
        set_state(sel, TX_BYTE); tick();
        set_state(sel, MACK);
        if (wr_mid && b == 0) begin
          bus_a.req      = 3'b100;
          bus_a.brush_in = 8'h77;
        end
        tick();
        bus_a.req = 3'b000;
        if (b != nbytes - 1) begin
          set_state(sel, NEXT_BYTE); tick();
        end
      end
    end
    set_state(sel, IDLE); tick();
  endtask

  task automatic test_reset();
    checks++; if (bus_a.gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", bus_a.gnt); end
    checks++; if (bus_a.x_pos !== 8'h00 || bus_a.y_pos !== 8'h00) begin errors++; $display("FAIL reset_xy got %h/%h want 00/00", bus_a.x_pos, bus_a.y_pos); end
    checks++; if (bus_a.status !== 8'h00 || bus_a.brush_status !== 8'h00) begin errors++; $display("FAIL reset_st_br got %h/%h want 00/00", bus_a.status, bus_a.brush_status); end
    checks++; if (bus_a.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus_a.irq); end
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame got %0d want 0", bus_a.frame_cnt); end
    checks++; if (bus_a.stale !== 1'b0 || bus_t.stale !== 1'b0) begin errors++; $display("FAIL reset_stale got %b/%b want 0/0", bus_a.stale, bus_t.stale); end
  endtask

  task automatic test_cursor_write();
    bus_a.req = 3'b001; bus_a.cur_x = 8'h12; bus_a.cur_y = 8'h34;
    #1;
    checks++; if (bus_a.gnt !== 3'b001) begin errors++; $display("FAIL cursor_gnt got %b want 001", bus_a.gnt); end
    tick();
    bus_a.req = 3'b000;
    checks++; if (bus_a.x_pos !== 8'h00) begin errors++; $display("FAIL cursor_latency got %h want 00", bus_a.x_pos); end
    tick();
    checks++; if (bus_a.x_pos !== 8'h12 || bus_a.y_pos !== 8'h34) begin errors++; $display("FAIL cursor_xy got %h/%h want 12/34", bus_a.x_pos, bus_a.y_pos); end
    checks++; if (bus_a.irq !== 1'b1) begin errors++; $display("FAIL cursor_irq got %b want 1", bus_a.irq); end
  endtask

  task automatic test_round_robin();
    // pointer is 1 after the cursor grant; brush grant brings it to 0
    bus_a.req = 3'b100; bus_a.brush_in = 8'h5C;
    #1;
    checks++; if (bus_a.gnt !== 3'b100) begin errors++; $display("FAIL rr_ptr1 got %b want 100", bus_a.gnt); end
    tick();
    bus_a.req = 3'b111; bus_a.status_in = 8'h01;
    #1;
    checks++; if (bus_a.gnt !== 3'b001) begin errors++; $display("FAIL rr_seq0 got %b want 001", bus_a.gnt); end
    tick();
    checks++; if (bus_a.gnt !== 3'b010) begin errors++; $display("FAIL rr_seq1 got %b want 010", bus_a.gnt); end
    tick();
    checks++; if (bus_a.gnt !== 3'b100) begin errors++; $display("FAIL rr_seq2 got %b want 100", bus_a.gnt); end
    tick();
    checks++; if (bus_a.gnt !== 3'b001) begin errors++; $display("FAIL rr_seq3 got %b want 001", bus_a.gnt); end
    bus_a.req = 3'b110; #1;
    checks++; if (bus_a.gnt !== 3'b010) begin errors++; $display("FAIL rr_p0_110 got %b want 010", bus_a.gnt); end
    bus_a.req = 3'b000; #1;
    checks++; if (bus_a.gnt !== 3'b000) begin errors++; $display("FAIL rr_none got %b want 000", bus_a.gnt); end
    bus_a.req = 3'b010;
    tick();
    bus_a.req = 3'b011; #1;
    checks++; if (bus_a.gnt !== 3'b001) begin errors++; $display("FAIL rr_wrap got %b want 001", bus_a.gnt); end
    bus_a.req = 3'b000;
    tick(2);
    checks++; if (bus_a.x_pos !== 8'h12 || bus_a.status !== 8'h01 || bus_a.brush_status !== 8'h5C) begin
      errors++; $display("FAIL rr_snapshot got %h/%h/%h want 12/01/5c", bus_a.x_pos, bus_a.status, bus_a.brush_status); end
  endtask

  task automatic test_freeze();
    set_state(0, ADDR_SHIFT);
    tick();
    bus_a.req = 3'b010; bus_a.status_in = 8'hAA;
    #1;
    checks++; if (bus_a.gnt !== 3'b010) begin errors++; $display("FAIL freeze_gnt got %b want 010", bus_a.gnt); end
    tick();
    bus_a.req = 3'b000;
    tick(2);
    checks++; if (bus_a.status !== 8'h01) begin errors++; $display("FAIL freeze_hold got %h want 01", bus_a.status); end
    set_state(0, IDLE);
    tick();
    checks++; if (bus_a.status !== 8'hAA) begin errors++; $display("FAIL freeze_release got %h want aa", bus_a.status); end
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL freeze_frame got %0d want 0", bus_a.frame_cnt); end
  endtask

  task automatic test_full_read();
    checks++; if (bus_a.irq !== 1'b1) begin errors++; $display("FAIL read_pre_irq got %b want 1", bus_a.irq); end
    run_read(0, 4, 0, 0);
    checks++; if (bus_a.irq !== 1'b0 || bus_a.frame_cnt !== 8'd1) begin errors++; $display("FAIL read1 irq/frame got %b/%0d want 0/1", bus_a.irq, bus_a.frame_cnt); end
    run_read(0, 4, 1, 0);
    checks++; if (bus_a.irq !== 1'b1 || bus_a.frame_cnt !== 8'd2) begin errors++; $display("FAIL read2 irq/frame got %b/%0d want 1/2", bus_a.irq, bus_a.frame_cnt); end
    checks++; if (bus_a.brush_status !== 8'h77) begin errors++; $display("FAIL read2_brush got %h want 77", bus_a.brush_status); end
    // nine bytes: the byte counter must saturate, not wrap below four
    run_read(0, 9, 0, 0);
    checks++; if (bus_a.irq !== 1'b0 || bus_a.frame_cnt !== 8'd3) begin errors++; $display("FAIL read_long irq/frame got %b/%0d want 0/3", bus_a.irq, bus_a.frame_cnt); end
  endtask

  task automatic test_abort();
    run_read(0, 2, 0, 0);
    checks++; if (bus_a.irq !== 1'b0 || bus_a.frame_cnt !== 8'd3) begin errors++; $display("FAIL abort_2byte irq/frame got %b/%0d want 0/3", bus_a.irq, bus_a.frame_cnt); end
    run_read(0, 0, 0, 1);
    checks++; if (bus_a.irq !== 1'b0 || bus_a.frame_cnt !== 8'd3) begin errors++; $display("FAIL abort_nack irq/frame got %b/%0d want 0/3", bus_a.irq, bus_a.frame_cnt); end
    run_read(0, 2, 1, 0);
    checks++; if (bus_a.irq !== 1'b1 || bus_a.frame_cnt !== 8'd3) begin errors++; $display("FAIL abort_wr irq/frame got %b/%0d want 1/3", bus_a.irq, bus_a.frame_cnt); end
    // pending was folded into dirty on the abort, so a clean read clears irq
    run_read(0, 4, 0, 0);
    checks++; if (bus_a.irq !== 1'b0 || bus_a.frame_cnt !== 8'd4) begin errors++; $display("FAIL abort_after irq/frame got %b/%0d want 0/4", bus_a.irq, bus_a.frame_cnt); end
  endtask

  task automatic test_frame_wrap();
    for (int i = 0; i < 251; i++) run_read(0, 4, 0, 0);
    checks++; if (bus_a.frame_cnt !== 8'd255) begin errors++; $display("FAIL frame_255 got %0d want 255", bus_a.frame_cnt); end
    run_read(0, 4, 0, 0);
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL frame_wrap got %0d want 0", bus_a.frame_cnt); end
  endtask

  task automatic test_timeout();
    bus_t.req = 3'b001; bus_t.cur_x = 8'h11; bus_t.cur_y = 8'h22;
    tick();
    bus_t.req = 3'b000;
    tick();
    checks++; if (bus_t.x_pos !== 8'h11) begin errors++; $display("FAIL to_pre_x got %h want 11", bus_t.x_pos); end
    set_state(1, ADDR_SHIFT);
    for (int e = 1; e <= 20; e++) begin
      if (e == 3)  begin bus_t.req = 3'b010; bus_t.status_in = 8'h5A; end
      if (e == 12) begin bus_t.req = 3'b001; bus_t.cur_x = 8'h99; bus_t.cur_y = 8'h88; end
      tick();
      bus_t.req = 3'b000;
      if (e == 7) begin
        checks++; if (bus_t.stale !== 1'b0) begin errors++; $display("FAIL to_stale7 got %b want 0", bus_t.stale); end
      end
      if (e == 8) begin
        checks++; if (bus_t.stale !== 1'b1) begin errors++; $display("FAIL to_stale8 got %b want 1", bus_t.stale); end
        checks++; if (bus_t.status !== 8'h00) begin errors++; $display("FAIL to_status8 got %h want 00", bus_t.status); end
      end
      if (e == 9) begin
        checks++; if (bus_t.status !== 8'h5A) begin errors++; $display("FAIL to_status9 got %h want 5a", bus_t.status); end
      end
      if (e == 12) begin
        checks++; if (bus_t.x_pos !== 8'h11) begin errors++; $display("FAIL to_x12 got %h want 11", bus_t.x_pos); end
      end
      if (e == 13) begin
        checks++; if (bus_t.x_pos !== 8'h99 || bus_t.y_pos !== 8'h88) begin errors++; $display("FAIL to_xy13 got %h/%h want 99/88", bus_t.x_pos, bus_t.y_pos); end
      end
    end
    set_state(1, IDLE);
    tick();
    checks++; if (bus_t.stale !== 1'b0) begin errors++; $display("FAIL to_stale_clear got %b want 0", bus_t.stale); end
    // a 4-byte read lasts longer than 8 cycles here, so it times out and
    // must not count
    run_read(1, 4, 0, 0);
    checks++; if (bus_t.frame_cnt !== 8'd0 || bus_t.irq !== 1'b1) begin errors++; $display("FAIL to_read frame/irq got %0d/%b want 0/1", bus_t.frame_cnt, bus_t.irq); end
    checks++; if (bus_t.stale !== 1'b0) begin errors++; $display("FAIL to_read_stale got %b want 0", bus_t.stale); end
  endtask

  initial begin
    bus_a.i2c_state = IDLE; bus_a.req = 3'b000;
    bus_a.cur_x = 8'h00; bus_a.cur_y = 8'h00; bus_a.status_in = 8'h00; bus_a.brush_in = 8'h00;
    bus_t.i2c_state = IDLE; bus_t.req = 3'b000;
    bus_t.cur_x = 8'h00; bus_t.cur_y = 8'h00; bus_t.status_in = 8'h00; bus_t.brush_in = 8'h00;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();
    test_reset();
    test_cursor_write();
    test_round_robin();
    test_freeze();
    test_full_read();
    test_abort();
    test_frame_wrap();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
